// File: rtl/counting_pkg.sv
// ============================================================================
//  Module  : counting_pkg
//  Brief   : Shared symbol constants and feeder FSM state type for the
//            counting_feeder byte-to-symbol serializer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package counting_pkg;

  // Width of one serialized symbol.
  localparam int SYM_W = 2;

  localparam logic [SYM_W-1:0] SYM_0 = 2'b00;
  localparam logic [SYM_W-1:0] SYM_1 = 2'b01;
  localparam logic [SYM_W-1:0] SYM_2 = 2'b10;
  localparam logic [SYM_W-1:0] SYM_3 = 2'b11;

  // Serializer control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/counting_fifo.sv
// ============================================================================
//  Module  : counting_fifo
//  Brief   : Byte FIFO with occupancy count. DEPTH must be a power of two
//            (>= 2) so the read/write pointers wrap naturally.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module counting_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Writes into a full FIFO and reads from an empty one are dropped.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointer/count; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care once the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/counting_feeder.sv
// ============================================================================
//  Module  : counting_feeder
//  Brief   : Buffers bytes in a small FIFO and serializes each byte into four
//            2-bit symbols, one per cycle, for a downstream sequence detector.
//            Back-to-back bytes stream with no gap cycle.
//  Config  : COUNTING_FEEDER_LSB_FIRST_EN - when defined, symbols leave each
//            byte starting at bits [1:0]; otherwise starting at bits [7:6].
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module counting_feeder
  import counting_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [SYM_W-1:0] IDLE_SYM = 2'b00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] num,
  output logic             num_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  feeder_state_e    state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [1:0]       sym_idx_q, sym_idx_d;
  logic [SYM_W-1:0] num_q, num_d;
  logic             num_valid_q, num_valid_d;

  logic             pop;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_has_data;
  logic [1:0]       sym_lane;
  logic [SYM_W-1:0] cur_sym;

  counting_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Acceptance depends only on the registered count, never on in_valid.
  assign fifo_has_data = (fifo_count != '0);
  assign in_ready      = ~fifo_full;
  assign busy          = (state_q == SHIFT) | ~fifo_empty;
  assign num           = num_q;
  assign num_valid     = num_valid_q;

  // Select the 2-bit lane of the held byte addressed by the symbol index.
  always_comb begin
    cur_sym = IDLE_SYM;
`ifdef COUNTING_FEEDER_LSB_FIRST_EN
    sym_lane = sym_idx_q;
`else
    sym_lane = ~sym_idx_q;
`endif
    case (sym_lane)
      2'd0:    cur_sym = shreg_q[1:0];
      2'd1:    cur_sym = shreg_q[3:2];
      2'd2:    cur_sym = shreg_q[5:4];
      default: cur_sym = shreg_q[7:6];
    endcase
  end

  // Serializer control: load a byte when idle, emit four symbols, and chain
  // straight into the next byte on the last symbol if one is waiting.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    sym_idx_d   = sym_idx_q;
    num_d       = IDLE_SYM;
    num_valid_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_has_data) begin
          pop       = 1'b1;
          shreg_d   = fifo_rdata;
          sym_idx_d = 2'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        num_d       = cur_sym;
        num_valid_d = 1'b1;
        if (sym_idx_q == 2'd3) begin
          sym_idx_d = 2'd0;
          if (fifo_has_data) begin
            pop     = 1'b1;
            shreg_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sym_idx_d = sym_idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset drops any partially sent byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      sym_idx_q   <= '0;
      num_q       <= IDLE_SYM;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      sym_idx_q   <= sym_idx_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counting_feeder.sv
// ============================================================================
//  Module  : tb_counting_feeder
//  Brief   : Self-checking bench for counting_feeder. A queue-based reference
//            model predicts every cycle's outputs; directed scenarios are
//            followed by randomized traffic with occasional resets.
//  Config  : honours COUNTING_FEEDER_LSB_FIRST_EN for the expected order.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counting_feeder;

  localparam int         DEPTH    = 4;
  localparam logic [1:0] IDLE_SYM = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] num;
  logic       num_valid;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: bytes waiting, and symbols still to be emitted.
  logic [7:0] m_fifo [$];
  logic [1:0] m_cur  [$];

  // Observed valid symbols and the edge index they appeared after.
  logic [1:0] obs_sym [$];
  int         obs_cyc [$];

  counting_feeder #(
    .DEPTH    (DEPTH),
    .IDLE_SYM (IDLE_SYM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .num_valid (num_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // k-th symbol sent for byte b.
  function automatic logic [1:0] sym_of(input logic [7:0] b, input int k);
    logic [7:0] t;
`ifdef COUNTING_FEEDER_LSB_FIRST_EN
    t = b >> (2 * k);
`else
    t = b >> (6 - 2 * k);
`endif
    return t[1:0];
  endfunction

  // One clock edge: advance the model with the pre-edge inputs, then compare.
  task automatic step();
    logic [1:0] e_sym;
    logic       e_val;
    int         pre;
    logic [7:0] b;
    @(posedge clk);
    cyc++;
    pre   = m_fifo.size();
    e_val = 1'b0;
    e_sym = IDLE_SYM;
    if (m_cur.size() > 0) begin
      e_sym = m_cur.pop_front();
      e_val = 1'b1;
    end
    if (m_cur.size() == 0 && pre > 0) begin
      b = m_fifo.pop_front();
      for (int k = 0; k < 4; k++) m_cur.push_back(sym_of(b, k));
    end
    if (in_valid && pre != DEPTH) m_fifo.push_back(in_data);
    #1;
    chk("num",       32'(num),       32'(e_sym));
    chk("num_valid", 32'(num_valid), 32'(e_val));
    chk("in_ready",  32'(in_ready),  32'(m_fifo.size() != DEPTH));
    chk("busy",      32'(busy),      32'(m_cur.size() > 0 || m_fifo.size() > 0));
    if (num_valid) begin
      obs_sym.push_back(num);
      obs_cyc.push_back(cyc);
    end
  endtask

  // Asynchronous reset: outputs must settle without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    m_fifo.delete();
    m_cur.delete();
    #1;
    chk("rst_num",   32'(num),       32'(IDLE_SYM));
    chk("rst_valid", 32'(num_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp1 [4];
    logic [7:0] fill [6];
    int         p;
    int         idx;
    int         guard;
    bit         saw_full;

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    do_reset();

    // Single byte 8'h1B: four symbols, first one two edges after the push.
`ifdef COUNTING_FEEDER_LSB_FIRST_EN
    exp1 = '{2'b11, 2'b10, 2'b01, 2'b00};
`else
    exp1 = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    obs_sym.delete(); obs_cyc.delete();
    in_valid = 1'b1; in_data = 8'h1B;
    step();
    p = cyc;
    in_valid = 1'b0;
    repeat (8) step();
    chk("single_cnt", 32'(obs_sym.size()), 32'd4);
    if (obs_sym.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("single_sym", 32'(obs_sym[k]), 32'(exp1[k]));
      chk("single_lat", 32'(obs_cyc[0] - p), 32'd2);
    end
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Two bytes back to back: eight contiguous symbols.
    obs_sym.delete(); obs_cyc.delete();
    in_valid = 1'b1; in_data = 8'h6C; step();
    in_data = 8'hFF; step();
    in_valid = 1'b0;
    repeat (12) step();
    chk("b2b_cnt", 32'(obs_sym.size()), 32'd8);
    if (obs_sym.size() == 8) begin
      for (int k = 0; k < 4; k++) chk("b2b_sym0", 32'(obs_sym[k]),     32'(sym_of(8'h6C, k)));
      for (int k = 0; k < 4; k++) chk("b2b_sym1", 32'(obs_sym[4 + k]), 32'(sym_of(8'hFF, k)));
      chk("b2b_nogap", 32'(obs_cyc[7] - obs_cyc[0]), 32'd7);
    end

    // Hold in_valid with six bytes: FIFO fills, nothing is lost.
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    obs_sym.delete(); obs_cyc.delete();
    idx = 0; guard = 0; saw_full = 1'b0;
    in_valid = 1'b1;
    while (idx < 6 && guard < 100) begin
      bit acc;
      in_data = fill[idx];
      acc = (m_fifo.size() != DEPTH);
      step();
      if (acc) idx++;
      if (!in_ready) saw_full = 1'b1;
      guard++;
    end
    chk("fill_timeout", 32'(idx), 32'd6);
    in_valid = 1'b0;
    repeat (30) step();
    chk("fill_full_seen", 32'(saw_full), 32'd1);
    chk("fill_cnt", 32'(obs_sym.size()), 32'd24);
    if (obs_sym.size() == 24)
      for (int i = 0; i < 6; i++)
        for (int k = 0; k < 4; k++)
          chk("fill_sym", 32'(obs_sym[4 * i + k]), 32'(sym_of(fill[i], k)));

    // Reset after the 2nd symbol of 8'hA5 with two bytes queued.
    obs_sym.delete(); obs_cyc.delete();
    in_valid = 1'b1; in_data = 8'hA5; step();
    in_data = 8'h3C; step();
    in_data = 8'hC3; step();
    in_valid = 1'b0;
    guard = 0;
    while (obs_sym.size() < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("mid_timeout", 32'(obs_sym.size()), 32'd2);
    in_valid = 1'b1; in_data = 8'h5A;
    do_reset();
    obs_sym.delete(); obs_cyc.delete();
    step();
    in_valid = 1'b0;
    repeat (12) step();
    chk("post_rst_cnt", 32'(obs_sym.size()), 32'd4);
    if (obs_sym.size() == 4)
      for (int k = 0; k < 4; k++) chk("post_rst_sym", 32'(obs_sym[k]), 32'(sym_of(8'h5A, k)));

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
